// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU control codes and datapath select codes.
package mips_multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_B_REG   = 2'b00;
   localparam logic [1:0] SRC_B_FOUR  = 2'b01;
   localparam logic [1:0] SRC_B_IMM   = 2'b10;
   localparam logic [1:0] SRC_B_SHIFT = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_alu_control_decode.sv
// Maps the FSM's coarse ALU request plus the R-type funct field onto the
// 4-bit ALU control code, and flags whether the funct is supported.
module alu_control_decode
   import mips_multicycle_control_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_control,
   output logic       funct_ok
);

   logic [3:0] funct_code;

   always_comb begin
      funct_code = ALU_ADD;
      funct_ok   = 1'b1;
      case (funct)
         FN_ADD:  funct_code = ALU_ADD;
         FN_SUB:  funct_code = ALU_SUB;
         FN_AND:  funct_code = ALU_AND;
         FN_OR:   funct_code = ALU_OR;
         FN_SLT:  funct_code = ALU_SLT;
         FN_NOR:  funct_code = ALU_NOR;
         default: funct_ok   = 1'b0;
      endcase
   end

   always_comb begin
      case (alu_op)
         ALU_OP_SUB:   alu_control = ALU_SUB;
         ALU_OP_FUNCT: alu_control = funct_code;
         default:      alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath: sequences each
// instruction and drives enables, selects and the ALU control code.
module mips_multicycle_control
   import mips_multicycle_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [3:0] alu_control,
   output logic       illegal,
   output logic [3:0] state
);

   state_t     state_reg;
   state_t     state_next;
   logic [5:0] op_q;
   logic [5:0] fn_q;

   logic       fsm_pc_write;
   logic       fsm_pc_write_cond;
   logic       fsm_mem_read;
   logic       fsm_mem_write;
   logic       fsm_ir_write;
   logic       fsm_reg_write;
   logic       fsm_illegal;
   logic [1:0] alu_op;
   logic [5:0] dec_funct;
   logic       funct_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_FETCH;
         op_q      <= '0;
         fn_q      <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_DECODE) begin
            op_q <= opcode;
            fn_q <= funct;
         end
      end
   end

   // Legality is judged on the live funct in DECODE; alu_op is ADD there, so
   // alu_control never sees the live field.
   assign dec_funct = (state_reg == S_DECODE) ? funct : fn_q;

   alu_control_decode u_alu_control_decode (
      .alu_op      (alu_op),
      .funct       (dec_funct),
      .alu_control (alu_control),
      .funct_ok    (funct_ok)
   );

   always_comb begin
      state_next        = S_FETCH;
      fsm_pc_write      = 1'b0;
      fsm_pc_write_cond = 1'b0;
      fsm_mem_read      = 1'b0;
      fsm_mem_write     = 1'b0;
      fsm_ir_write      = 1'b0;
      fsm_reg_write     = 1'b0;
      fsm_illegal       = 1'b0;
      alu_op            = ALU_OP_ADD;
      i_or_d            = 1'b0;
      reg_dst           = 1'b0;
      mem_to_reg        = 1'b0;
      alu_src_a         = 1'b0;
      alu_src_b         = SRC_B_REG;
      pc_source         = PCSRC_ALU;

      case (state_reg)
         S_FETCH: begin
            fsm_mem_read = 1'b1;
            fsm_ir_write = 1'b1;
            fsm_pc_write = 1'b1;
            alu_src_b    = SRC_B_FOUR;
            state_next   = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = SRC_B_SHIFT;
            case (opcode)
               OP_RTYPE: begin
                  if (funct_ok) state_next = S_EXECUTE;
                  else          fsm_illegal = 1'b1;
               end
               OP_LW, OP_SW: state_next  = S_MEM_ADDR;
               OP_BEQ:       state_next  = S_BRANCH;
               OP_J:         state_next  = S_JUMP;
               OP_ADDI:      state_next  = S_ADDI_EXEC;
               default:      fsm_illegal = 1'b1;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            state_next = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            fsm_mem_read = 1'b1;
            i_or_d       = 1'b1;
            state_next   = S_MEM_WB;
         end
         S_MEM_WB: begin
            fsm_reg_write = 1'b1;
            mem_to_reg    = 1'b1;
         end
         S_MEM_WRITE: begin
            fsm_mem_write = 1'b1;
            i_or_d        = 1'b1;
         end
         S_EXECUTE: begin
            alu_op     = ALU_OP_FUNCT;
            alu_src_a  = 1'b1;
            state_next = S_R_WB;
         end
         S_R_WB: begin
            fsm_reg_write = 1'b1;
            reg_dst       = 1'b1;
         end
         S_BRANCH: begin
            alu_op            = ALU_OP_SUB;
            alu_src_a         = 1'b1;
            fsm_pc_write_cond = 1'b1;
            pc_source         = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            fsm_pc_write = 1'b1;
            pc_source    = PCSRC_JUMP;
         end
         S_ADDI_EXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            state_next = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            fsm_reg_write = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Strobes are suppressed while reset is held; selects keep FETCH values.
   assign pc_en     = ~rst & (fsm_pc_write | (fsm_pc_write_cond & zero));
   assign mem_read  = ~rst & fsm_mem_read;
   assign mem_write = ~rst & fsm_mem_write;
   assign ir_write  = ~rst & fsm_ir_write;
   assign reg_write = ~rst & fsm_reg_write;
   assign illegal   = ~rst & fsm_illegal;
   assign state     = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench: each instruction's expected state walk and
// per-state outputs come from a reference model of the instruction set.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
   logic       mem_to_reg, reg_write, alu_src_a, illegal;
   logic [1:0] alu_src_b, pc_source;
   logic [3:0] alu_control, state;
   logic [17:0] outs_vec;

   int assert_count = 0;
   int fail_count   = 0;

   mips_multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .alu_control(alu_control), .illegal(illegal),
      .state(state)
   );

   always #5 clk = ~clk;

   assign outs_vec = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                      alu_control, illegal};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_count++;
      if (got !== exp) begin
         fail_count++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Control word the datapath should see in a given state.
   function automatic logic [17:0] exp_outs(input int st, input logic [3:0] rcode,
                                            input logic z, input logic ill);
      logic pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, sa;
      logic [1:0] sb, ps;
      logic [3:0] alu;
      {pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, sa} = '0;
      sb = 2'd0; ps = 2'd0; alu = 4'b0010;
      case (st)
         0:  begin mr = 1; irw = 1; pcw = 1; sb = 2'd1; end
         1:  sb = 2'd3;
         2:  begin sa = 1; sb = 2'd2; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iord = 1; end
         6:  begin alu = rcode; sa = 1; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin alu = 4'b0110; sa = 1; pcwc = 1; ps = 2'd1; end
         9:  begin pcw = 1; ps = 2'd2; end
         10: begin sa = 1; sb = 2'd2; end
         11: rw = 1;
         default: ;
      endcase
      return {pcw | (pcwc & z), iord, mr, mw, irw, rdst, m2r, rw, sa, sb, ps, alu, ill};
   endfunction

   // Runs one instruction from FETCH. zmode 0/1 forces zero, 2 randomizes it.
   // cut >= 0 stops at the low phase of that cycle index without advancing.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int zmode, input int cut, input string name);
      int seq[5];
      int len;
      logic [3:0] rcode;
      logic ill;
      logic z;
      rcode = 4'b0010;
      ill   = 1'b0;
      seq   = '{0, 1, 0, 0, 0};
      len   = 2;
      case (op)
         6'b000000: begin
            seq = '{0, 1, 6, 7, 0}; len = 4;
            case (fn)
               6'b100000: rcode = 4'b0010;
               6'b100010: rcode = 4'b0110;
               6'b100100: rcode = 4'b0000;
               6'b100101: rcode = 4'b0001;
               6'b101010: rcode = 4'b0111;
               6'b100111: rcode = 4'b1100;
               default: begin ill = 1'b1; len = 2; end
            endcase
         end
         6'b100011: begin seq = '{0, 1, 2, 3, 4}; len = 5; end
         6'b101011: begin seq = '{0, 1, 2, 5, 0}; len = 4; end
         6'b000100: begin seq = '{0, 1, 8, 0, 0}; len = 3; end
         6'b000010: begin seq = '{0, 1, 9, 0, 0}; len = 3; end
         6'b001000: begin seq = '{0, 1, 10, 11, 0}; len = 4; end
         default:   ill = 1'b1;
      endcase
      for (int i = 0; i < len; i++) begin
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
         zero = z;
         if (seq[i] == 1) begin
            opcode = op;
            funct  = fn;
         end else begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
         end
         @(negedge clk);
         check_val($sformatf("%s state c%0d", name, i), 32'(state), 32'(seq[i]));
         check_val($sformatf("%s outs c%0d", name, i), 32'(outs_vec),
                   32'(exp_outs(seq[i], rcode, z, ill && (seq[i] == 1))));
         $display("%s op=%b fn=%b cycle %0d state=%0d", name, op, fn, i, state);
         if (i == cut) return;
         @(posedge clk);
         #1;
      end
   endtask

   // Reset values: state 0, FETCH selects, every strobe low.
   localparam logic [17:0] RESET_OUTS = {9'b0, 2'b01, 2'b00, 4'b0010, 1'b0};

   task automatic check_reset(input string tag);
      check_val({tag, " state"}, 32'(state), 32'd0);
      check_val({tag, " outs"}, 32'(outs_vec), 32'(RESET_OUTS));
      $display("%s state=%0d outs=%05h", tag, state, outs_vec);
   endtask

   logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   logic [5:0] legal_fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

   initial begin
      logic [5:0] op, fn;
      zero = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset($sformatf("power-on reset c%0d", i));
      end
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_instr(6'b000000, legal_fns[i], 2, -1, "rtype");
      run_instr(6'b100011, 6'($urandom), 2, -1, "lw");
      run_instr(6'b101011, 6'($urandom), 2, -1, "sw");
      run_instr(6'b000100, 6'($urandom), 1, -1, "beq taken");
      run_instr(6'b000100, 6'($urandom), 0, -1, "beq not-taken");
      run_instr(6'b000010, 6'($urandom), 2, -1, "j");
      run_instr(6'b001000, 6'($urandom), 2, -1, "addi");
      run_instr(6'b111111, 6'b100000, 2, -1, "illegal op");
      run_instr(6'b000000, 6'b000000, 2, -1, "illegal funct");

      // Abort an slt in EXECUTE with an asynchronous reset.
      run_instr(6'b000000, 6'b101010, 2, 2, "slt abort");
      #1 rst = 1'b1; zero = 1'b1;
      #1 check_reset("async reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset($sformatf("held reset c%0d", i));
      end
      @(posedge clk); #1 rst = 1'b0;
      run_instr(6'b100011, 6'($urandom), 2, -1, "lw after reset");

      for (int n = 0; n < 200; n++) begin
         op = ($urandom_range(0, 7) < 6) ? legal_ops[$urandom_range(0, 5)] : 6'($urandom);
         fn = ($urandom_range(0, 3) != 0) ? legal_fns[$urandom_range(0, 5)] : 6'($urandom);
         run_instr(op, fn, 2, -1, $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
